// File: rtl/grid_line_clear.sv
// grid_line_clear: scans the Tetris grid bottom-up, drops full rows, slides surviving rows down
// and zero-fills the vacated top rows. Drives port A of a synchronous-read grid RAM (1-cycle read latency).
module grid_line_clear #(
  parameter int COLS   = 10,
  parameter int ROWS   = 20,
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic [DATA_W-1:0] i_grid_rdata,
  output logic [ADDR_W-1:0] o_grid_addr,
  output logic [DATA_W-1:0] o_grid_wdata,
  output logic              o_grid_we,
  output logic              o_busy,
  output logic              o_done,
  output logic [4:0]        o_lines_cleared
);

  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_COPY, S_CLEAR, S_DONE} state_t;

  state_t            r_state;
  logic [4:0]        r_src;
  logic [4:0]        r_dst;
  logic [4:0]        r_cnt;
  logic [5:0]        r_step;
  logic              r_full;
  logic [DATA_W-1:0] r_hold;

  logic              w_row_full;
  logic              w_chk_end;
  logic              w_copy_end;
  logic              w_need_copy;
  logic              w_advance;
  logic              w_dst_dec;
  logic [4:0]        w_cnt_nx;
  logic [5:0]        w_step_nx;
  logic [5:0]        w_col_wr;
  logic [5:0]        w_col_rd;

  function automatic logic [ADDR_W-1:0] cell_addr(input logic [4:0] row, input logic [5:0] col);
    return ADDR_W'(int'(row) * COLS + int'(col));
  endfunction

  // Row-completion decisions and COPY column decode for the upcoming step.
  always_comb begin
    w_row_full  = r_full && (i_grid_rdata != {DATA_W{1'b0}});
    w_chk_end   = (r_state == S_CHECK) && (r_step == 6'(COLS));
    w_copy_end  = (r_state == S_COPY) && (r_step == 6'(2*COLS-1));
    w_need_copy = w_chk_end && !w_row_full && (r_src != r_dst);
    w_advance   = (w_chk_end && !w_need_copy) || w_copy_end;
    w_dst_dec   = !(w_chk_end && w_row_full) && (r_dst != 5'd0);
    if (w_chk_end && w_row_full && (r_cnt != 5'(ROWS))) begin
      w_cnt_nx = r_cnt + 5'd1;
    end else begin
      w_cnt_nx = r_cnt;
    end
    w_step_nx = r_step + 6'd1;
    w_col_wr  = (w_step_nx - 6'd2) >> 1;
    w_col_rd  = (w_step_nx + 6'd1) >> 1;
  end

  // Control FSM; every output is a register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state         <= S_IDLE;
      r_src           <= 5'd0;
      r_dst           <= 5'd0;
      r_cnt           <= 5'd0;
      r_step          <= 6'd0;
      r_full          <= 1'b0;
      r_hold          <= {DATA_W{1'b0}};
      o_grid_addr     <= {ADDR_W{1'b0}};
      o_grid_wdata    <= {DATA_W{1'b0}};
      o_grid_we       <= 1'b0;
      o_busy          <= 1'b0;
      o_done          <= 1'b0;
      o_lines_cleared <= 5'd0;
    end else begin
      r_hold <= i_grid_rdata;
      case (r_state)
        S_IDLE: begin
          o_grid_we <= 1'b0;
          if (i_start) begin
            r_state         <= S_CHECK;
            o_busy          <= 1'b1;
            r_src           <= 5'(ROWS-1);
            r_dst           <= 5'(ROWS-1);
            r_cnt           <= 5'd0;
            o_lines_cleared <= 5'd0;
            r_step          <= 6'd0;
            r_full          <= 1'b1;
            o_grid_addr     <= cell_addr(5'(ROWS-1), 6'd0);
          end
        end
        S_CHECK: begin
          o_grid_we <= 1'b0;
          r_step    <= w_step_nx;
          r_cnt     <= w_cnt_nx;
          if (r_step != 6'd0) r_full <= w_row_full;
          if (r_step < 6'(COLS-1)) o_grid_addr <= o_grid_addr + {{(ADDR_W-1){1'b0}}, 1'b1};
          if (w_need_copy) begin
            r_state     <= S_COPY;
            r_step      <= 6'd0;
            o_grid_addr <= cell_addr(r_src, 6'd0);
          end
        end
        // Reads run one cell ahead of writes; r_hold parks the word that lands on a write cycle.
        S_COPY: begin
          r_step <= w_step_nx;
          if (w_step_nx == 6'(2*COLS-1)) begin
            o_grid_addr  <= cell_addr(r_dst, 6'(COLS-1));
            o_grid_we    <= 1'b1;
            o_grid_wdata <= i_grid_rdata;
          end else if (!w_step_nx[0]) begin
            o_grid_addr  <= cell_addr(r_dst, w_col_wr);
            o_grid_we    <= 1'b1;
            o_grid_wdata <= (w_step_nx == 6'd2) ? i_grid_rdata : r_hold;
          end else begin
            o_grid_addr <= cell_addr(r_src, w_col_rd);
            o_grid_we   <= 1'b0;
          end
        end
        S_CLEAR: begin
          if (o_grid_addr == {ADDR_W{1'b0}}) begin
            r_state         <= S_DONE;
            o_grid_we       <= 1'b0;
            o_done          <= 1'b1;
            o_lines_cleared <= r_cnt;
          end else begin
            o_grid_addr  <= o_grid_addr - {{(ADDR_W-1){1'b0}}, 1'b1};
            o_grid_we    <= 1'b1;
            o_grid_wdata <= {DATA_W{1'b0}};
          end
        end
        S_DONE: begin
          r_state   <= S_IDLE;
          o_done    <= 1'b0;
          o_busy    <= 1'b0;
          o_grid_we <= 1'b0;
        end
        default: begin
          r_state   <= S_IDLE;
          o_done    <= 1'b0;
          o_busy    <= 1'b0;
          o_grid_we <= 1'b0;
        end
      endcase
      // A row is finished: step up a row, or leave the scan once row 0 has been handled.
      if (w_advance) begin
        if (r_src == 5'd0) begin
          if (w_cnt_nx != 5'd0) begin
            r_state      <= S_CLEAR;
            o_grid_addr  <= ADDR_W'(int'(w_cnt_nx) * COLS - 1);
            o_grid_we    <= 1'b1;
            o_grid_wdata <= {DATA_W{1'b0}};
          end else begin
            r_state         <= S_DONE;
            o_grid_we       <= 1'b0;
            o_done          <= 1'b1;
            o_lines_cleared <= w_cnt_nx;
          end
        end else begin
          r_state     <= S_CHECK;
          r_src       <= r_src - 5'd1;
          r_step      <= 6'd0;
          r_full      <= 1'b1;
          o_grid_we   <= 1'b0;
          o_grid_addr <= cell_addr(r_src - 5'd1, 6'd0);
        end
        if (w_dst_dec) r_dst <= r_dst - 5'd1;
      end
    end
  end

endmodule

// File: tb/tb_grid_line_clear.sv
// tb_grid_line_clear: directed and random grids run through grid_line_clear, with a RAM model on
// the grid port and a row-level reference model predicting writes, timing, final grid and row count.
module tb_grid_line_clear;
  localparam int COLS  = 10;
  localparam int ROWS  = 20;
  localparam int NCELL = COLS * ROWS;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] rdata = 8'h00;
  logic [7:0] addr;
  logic [7:0] wdata;
  logic       we;
  logic       busy;
  logic       done;
  logic [4:0] lines;

  always #5 clk = ~clk;

  grid_line_clear #(.COLS(COLS), .ROWS(ROWS), .ADDR_W(8), .DATA_W(8)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_grid_rdata(rdata),
    .o_grid_addr(addr), .o_grid_wdata(wdata), .o_grid_we(we),
    .o_busy(busy), .o_done(done), .o_lines_cleared(lines)
  );

  logic [7:0] mem  [NCELL];
  logic [7:0] g0   [NCELL];
  logic [7:0] gexp [NCELL];

  // Synchronous single-port grid RAM.
  always @(posedge clk) begin
    if (we && int'(addr) < NCELL) mem[addr] <= wdata;
    rdata <= (int'(addr) < NCELL) ? mem[addr] : 8'h00;
  end

  typedef struct { int addr; int data; } wr_t;
  wr_t wq[$];
  wr_t w;
  int  checks = 0, failures = 0;
  int  exp_cnt = 0, exp_lat = 0, cyc = 0, clr_wr = 0, done_cyc = 0;
  bit  run_on = 1'b0, quiet_chk = 1'b0;

  task automatic check_eq(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Reference: keep non-full rows in bottom-up order, stack them on the floor, empty the rest.
  task automatic build_model();
    int  kept[$];
    int  copied;
    int  d;
    bit  full;
    wq.delete();
    exp_cnt = 0;
    copied  = 0;
    for (int r = ROWS - 1; r >= 0; r--) begin
      full = 1'b1;
      for (int c = 0; c < COLS; c++) if (g0[r*COLS+c] == 8'h00) full = 1'b0;
      if (full) exp_cnt++;
      else kept.push_back(r);
    end
    for (int a = 0; a < NCELL; a++) gexp[a] = 8'h00;
    for (int k = 0; k < kept.size(); k++) begin
      d = ROWS - 1 - k;
      for (int c = 0; c < COLS; c++) gexp[d*COLS+c] = g0[kept[k]*COLS+c];
      if (kept[k] != d) begin
        copied++;
        for (int c = 0; c < COLS; c++) wq.push_back('{d*COLS+c, int'(g0[kept[k]*COLS+c])});
      end
    end
    exp_lat = ROWS*(COLS+1) + 2*COLS*copied + COLS*exp_cnt + 1;
  endtask

  // Per-cycle comparison of busy/done/write traffic against the model.
  always @(negedge clk) begin
    if (run_on) begin
      cyc++;
      check_eq("busy", int'(busy), (cyc <= exp_lat) ? 1 : 0);
      check_eq("done", int'(done), (cyc == exp_lat) ? 1 : 0);
      if (done && done_cyc == 0) done_cyc = cyc;
      if (we) begin
        if (wq.size() > 0) begin
          w = wq.pop_front();
          check_eq("copy_addr", int'(addr), w.addr);
          check_eq("copy_data", int'(wdata), w.data);
        end else begin
          clr_wr++;
          check_eq("clear_addr_in_range", (int'(addr) < exp_cnt*COLS) ? 1 : 0, 1);
          check_eq("clear_data", int'(wdata), 0);
        end
      end
      if (cyc > exp_lat) run_on = 1'b0;
    end else if (quiet_chk) begin
      check_eq("idle_we", int'(we), 0);
      check_eq("idle_done", int'(done), 0);
    end
  end

  task automatic clear_mem();
    for (int a = 0; a < NCELL; a++) mem[a] = 8'h00;
  endtask

  task automatic random_grid();
    bit full;
    for (int r = 0; r < ROWS; r++) begin
      full = ($urandom_range(0, 2) == 0);
      for (int c = 0; c < COLS; c++)
        mem[r*COLS+c] = (!full && $urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
      if (!full) mem[r*COLS + int'($urandom_range(0, COLS-1))] = 8'h00;
    end
  endtask

  // pulse2_at > 0: extra start pulse after that many cycles; < 0: extra pulse in the DONE cycle.
  task automatic run_test(input string name, input int pulse2_at);
    int guard, bad, p2;
    for (int a = 0; a < NCELL; a++) g0[a] = mem[a];
    build_model();
    p2 = (pulse2_at < 0) ? exp_lat - 1 : pulse2_at;
    @(negedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
    cyc      = 0;
    clr_wr   = 0;
    done_cyc = 0;
    run_on   = 1'b1;
    guard    = 0;
    while (run_on && guard < 3000) begin
      @(posedge clk); #1;
      guard++;
      start = (p2 > 0 && guard == p2);
    end
    start = 1'b0;
    check_eq({name, "_finished"}, run_on ? 0 : 1, 1);
    run_on = 1'b0;
    check_eq({name, "_lines"}, int'(lines), exp_cnt);
    check_eq({name, "_copy_writes_left"}, wq.size(), 0);
    check_eq({name, "_clear_writes"}, clr_wr, exp_cnt*COLS);
    bad = 0;
    for (int a = 0; a < NCELL; a++) if (mem[a] !== gexp[a]) bad++;
    check_eq({name, "_grid_cell_errors"}, bad, 0);
  endtask

  function automatic int count_nonzero();
    int n = 0;
    for (int a = 0; a < NCELL; a++) if (mem[a] != 8'h00) n++;
    return n;
  endfunction

  initial begin
    int z;
    clear_mem();
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_busy", int'(busy), 0);
    check_eq("rst_done", int'(done), 0);
    check_eq("rst_we", int'(we), 0);
    check_eq("rst_addr", int'(addr), 0);
    check_eq("rst_wdata", int'(wdata), 0);
    check_eq("rst_lines", int'(lines), 0);
    @(negedge clk);
    rst_n     = 1'b1;
    quiet_chk = 1'b1;

    clear_mem();
    run_test("empty", 0);
    check_eq("empty_model_latency", exp_lat, 221);
    check_eq("empty_done_cycle", done_cyc, 221);

    clear_mem();
    for (int c = 0; c < COLS; c++) mem[19*COLS+c] = 8'h01;
    mem[18*COLS+3] = 8'h05;
    run_test("row19", 0);
    check_eq("row19_model_latency", exp_lat, 611);
    check_eq("row19_done_cycle", done_cyc, 611);
    check_eq("row19_lines_literal", int'(lines), 1);
    check_eq("row19_cell_19_3", int'(mem[19*COLS+3]), 5);
    check_eq("row19_nonzero_cells", count_nonzero(), 1);

    clear_mem();
    for (int c = 0; c < COLS; c++) begin
      mem[19*COLS+c] = 8'h03;
      mem[17*COLS+c] = 8'h03;
    end
    mem[18*COLS+0] = 8'h02;
    run_test("rows19_17", 50);
    check_eq("rows19_17_lines_literal", int'(lines), 2);
    check_eq("rows19_17_cell_19_0", int'(mem[19*COLS+0]), 2);
    z = 0;
    for (int a = 0; a < 2*COLS; a++) if (mem[a] != 8'h00) z++;
    check_eq("rows19_17_top_rows_nonzero", z, 0);

    clear_mem();
    for (int c = 0; c < COLS-1; c++) mem[5*COLS+c] = 8'h07;
    run_test("row5_gap", 0);
    check_eq("row5_gap_lines_literal", int'(lines), 0);
    check_eq("row5_gap_cell_5_8", int'(mem[5*COLS+8]), 7);

    for (int a = 0; a < NCELL; a++) mem[a] = 8'($urandom_range(1, 255));
    run_test("all_full", 0);
    check_eq("all_full_model_latency", exp_lat, 421);
    check_eq("all_full_lines_literal", int'(lines), 20);
    check_eq("all_full_nonzero_cells", count_nonzero(), 0);

    clear_mem();
    for (int c = 0; c < COLS; c++) mem[19*COLS+c] = 8'h01;
    mem[18*COLS+3] = 8'h05;
    quiet_chk = 1'b0;
    @(negedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (299) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_eq("midrun_rst_busy", int'(busy), 0);
    check_eq("midrun_rst_done", int'(done), 0);
    check_eq("midrun_rst_we", int'(we), 0);
    check_eq("midrun_rst_addr", int'(addr), 0);
    @(negedge clk);
    rst_n     = 1'b1;
    quiet_chk = 1'b1;
    run_test("after_reset", 0);

    random_grid();
    run_test("start_in_done", -1);

    for (int i = 0; i < 8; i++) begin
      random_grid();
      run_test("random", (i % 2 == 1) ? int'($urandom_range(2, 200)) : 0);
    end

    repeat (5) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
